// File: rtl/data_mem_responder.sv
// Word-addressed data memory behind a req/ready/valid handshake, with a fixed
// number of wait states per access and an error response for bad addresses.
//   state | meaning
//   IDLE  | ready high, a request is captured on the next edge when req is high
//   WAIT  | request held, down-counter running toward the response
//   RESP  | one-cycle valid pulse carrying rdata/err, then back to IDLE
module data_mem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int IDX_W       = 6,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        valid,
  output logic [31:0] rdata,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam bit          NO_WAIT  = (WAIT_CYCLES == 0);
  localparam logic [3:0]  CNT_INIT = NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);
  localparam logic [29:0] DEPTH_L  = 30'(DEPTH_WORDS);

  state_t      state;
  logic [3:0]  cnt;
  logic        cap_we;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [31:0] mem [DEPTH_WORDS];

  logic             use_in;
  logic             tgt_we;
  logic [31:0]      tgt_addr;
  logic [31:0]      tgt_wdata;
  logic             enter_resp;
  logic             legal;
  logic [IDX_W-1:0] idx;

  assign ready = (state == IDLE);

  // With zero wait states the access happens on the accept edge itself,
  // so the live inputs stand in for the not-yet-captured request.
  assign use_in    = (state == IDLE);
  assign tgt_addr  = use_in ? addr  : cap_addr;
  assign tgt_wdata = use_in ? wdata : cap_wdata;
  assign tgt_we    = use_in ? we    : cap_we;

  assign enter_resp = ((state == IDLE) && req && NO_WAIT) ||
                      ((state == WAIT) && (cnt == 4'd0));
  assign legal      = (tgt_addr[1:0] == 2'b00) && (tgt_addr[31:2] < DEPTH_L);
  assign idx        = tgt_addr[IDX_W+1:2];

  // Array is never reset; gating on reset keeps an aborted access from landing.
  always_ff @(posedge clk) begin
    if (reset && enter_resp && legal && tgt_we) begin
      mem[idx] <= tgt_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      valid     <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            cap_we    <= we;
            cap_addr  <= addr;
            cap_wdata <= wdata;
            if (NO_WAIT) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state <= IDLE;
          valid <= 1'b0;
          err   <= 1'b0;
          rdata <= '0;
        end
        default: state <= IDLE;
      endcase

      if (enter_resp) begin
        valid <= 1'b1;
        if (!legal) begin
          err   <= 1'b1;
          rdata <= '0;
        end else if (tgt_we) begin
          err   <= 1'b0;
          rdata <= '0;
        end else begin
          err   <= 1'b0;
          rdata <= mem[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a transaction-level model scheduled by edge
// number is compared every cycle, plus literal checks on key responses.
module tb_data_mem_responder;

  localparam int WC    = 2;
  localparam int DEPTH = 64;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        req   = 1'b0;
  logic        we    = 1'b0;
  logic [31:0] addr  = '0;
  logic [31:0] wdata = '0;
  logic        ready;
  logic        valid;
  logic [31:0] rdata;
  logic        err;

  int total = 0;
  int bad   = 0;

  data_mem_responder #(
    .DEPTH_WORDS(DEPTH),
    .IDX_W(6),
    .WAIT_CYCLES(WC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .we(we),
    .addr(addr),
    .wdata(wdata),
    .ready(ready),
    .valid(valid),
    .rdata(rdata),
    .err(err)
  );

  always #5 clk = ~clk;

  // Model: a request accepted on edge n is answered on edge n+WC and the
  // responder is free again after edge n+WC+1.
  logic [31:0] m_mem   [DEPTH];
  bit          m_known [DEPTH];
  bit          m_busy    = 1'b0;
  int          edge_n    = 0;
  int          resp_at   = 0;
  logic        m_we      = 1'b0;
  logic [31:0] m_addr    = '0;
  logic [31:0] m_wdata   = '0;
  bit          x_ready   = 1'b1;
  bit          x_valid   = 1'b0;
  bit          x_err     = 1'b0;
  bit          x_rd_known = 1'b1;
  logic [31:0] x_rdata   = '0;

  always @(posedge clk) begin
    int unsigned w;
    if (!reset) begin
      m_busy     = 1'b0;
      x_valid    = 1'b0;
      x_err      = 1'b0;
      x_rdata    = '0;
      x_rd_known = 1'b1;
    end else begin
      if (m_busy && edge_n == resp_at + 1) begin
        m_busy     = 1'b0;
        x_valid    = 1'b0;
        x_err      = 1'b0;
        x_rdata    = '0;
        x_rd_known = 1'b1;
      end else if (!m_busy && req) begin
        m_busy  = 1'b1;
        resp_at = edge_n + WC;
        m_we    = we;
        m_addr  = addr;
        m_wdata = wdata;
      end
      if (m_busy && edge_n == resp_at) begin
        x_valid = 1'b1;
        w = m_addr / 4;
        if ((m_addr % 4) != 0 || w >= DEPTH) begin
          x_err      = 1'b1;
          x_rdata    = '0;
          x_rd_known = 1'b1;
        end else if (m_we) begin
          m_mem[w]   = m_wdata;
          m_known[w] = 1'b1;
          x_err      = 1'b0;
          x_rdata    = '0;
          x_rd_known = 1'b1;
        end else begin
          x_err      = 1'b0;
          x_rdata    = m_mem[w];
          x_rd_known = m_known[w];
        end
      end
    end
    x_ready = !m_busy;
    edge_n++;
  end

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } lit_t;
  lit_t lits[$];

  task automatic pin(input string n, input logic [31:0] a, input logic [31:0] e);
    lit_t l;
    l.name = n;
    l.act  = a;
    l.exp  = e;
    lits.push_back(l);
  endtask

  task automatic cmp(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got 0x%h expected 0x%h at t=%0t", n, a, e, $time);
    end
  endtask

  // Single compare process: per-cycle model checks and queued literal checks.
  always @(negedge clk) begin
    lit_t l;
    cmp("ready", 32'(ready), 32'(x_ready));
    cmp("valid", 32'(valid), 32'(x_valid));
    cmp("err",   32'(err),   32'(x_err));
    if (x_rd_known) cmp("rdata", rdata, x_rdata);
    while (lits.size() > 0) begin
      l = lits.pop_front();
      cmp(l.name, l.act, l.exp);
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ready) pin("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic e, output int lat);
    wait_ready();
    req   = 1'b1;
    we    = w;
    addr  = a;
    wdata = d;
    @(negedge clk);
    req   = 1'b0;
    we    = ~w;
    addr  = 32'hFFFF_FFFF;
    wdata = 32'h0BAD_0BAD;
    lat   = 1;
    while (!valid && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    rd = rdata;
    e  = err;
    if (!valid) pin("valid_timeout", 32'd0, 32'd1);
    we = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        e;
    int          lat;
    int          nv;
    int          nr;
    logic [31:0] blist [3];

    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    pin("rst_ready", 32'(ready), 32'd1);
    pin("rst_valid", 32'(valid), 32'd0);
    pin("rst_err",   32'(err),   32'd0);
    pin("rst_rdata", rdata,      32'd0);
    #1 reset = 1'b1;
    @(negedge clk);

    txn(1'b1, 32'h10, 32'hDEAD_BEEF, rd, e, lat);
    pin("store_latency", 32'(lat), 32'd3);
    pin("store_err",     32'(e),   32'd0);
    txn(1'b0, 32'h10, 32'h0, rd, e, lat);
    pin("load_latency", 32'(lat), 32'd3);
    pin("load_data",    rd,       32'hDEAD_BEEF);
    pin("load_err",     32'(e),   32'd0);

    txn(1'b0, 32'h13, 32'h0, rd, e, lat);
    pin("misalign_err",   32'(e), 32'd1);
    pin("misalign_rdata", rd,     32'd0);
    txn(1'b0, 32'h10, 32'h0, rd, e, lat);
    pin("reload_data", rd, 32'hDEAD_BEEF);

    txn(1'b1, 32'h0, 32'hCAFE_F00D, rd, e, lat);
    txn(1'b1, 32'h100, 32'h1234_5678, rd, e, lat);
    pin("range_err",   32'(e), 32'd1);
    pin("range_rdata", rd,     32'd0);
    txn(1'b0, 32'h0, 32'h0, rd, e, lat);
    pin("word0_data", rd, 32'hCAFE_F00D);

    // Continuous req with a new address every cycle.
    wait_ready();
    blist[0] = 32'h10;
    blist[1] = 32'h0;
    blist[2] = 32'h13;
    nv  = 0;
    nr  = 0;
    req = 1'b1;
    we  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      addr = blist[i % 3];
      @(negedge clk);
      if (valid) nv++;
      if (!ready) nr++;
    end
    req = 1'b0;
    pin("busy_valid_count",    32'(nv), 32'd4);
    pin("busy_notready_count", 32'(nr), 32'd12);

    txn(1'b1, 32'h20, 32'h1111_2222, rd, e, lat);
    wait_ready();
    req   = 1'b1;
    we    = 1'b1;
    addr  = 32'h20;
    wdata = 32'hA5A5_A5A5;
    @(negedge clk);
    req = 1'b0;
    we  = 1'b0;
    pin("abort_busy", 32'(ready), 32'd0);
    #1 reset = 1'b0;
    nv = 0;
    repeat (3) begin
      @(negedge clk);
      if (valid) nv++;
    end
    #1 reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (valid) nv++;
    end
    pin("abort_no_valid", 32'(nv),    32'd0);
    pin("abort_idle",     32'(ready), 32'd1);
    txn(1'b0, 32'h20, 32'h0, rd, e, lat);
    pin("abort_prior_data", rd, 32'h1111_2222);

    repeat (2) @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
